// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: glyph table, decoder and receiver FSM states.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

   typedef enum logic {S_FIRST, S_RUN} rx_state_t;

   // Returns {legal, digit}; blank and unknown patterns both report legal=0.
   function automatic logic [4:0] seg7_decode(input logic [6:0] seg);
      logic [4:0] res;
      case (seg)
         SEG_0:   res = {1'b1, 4'h0};
         SEG_1:   res = {1'b1, 4'h1};
         SEG_2:   res = {1'b1, 4'h2};
         SEG_3:   res = {1'b1, 4'h3};
         SEG_4:   res = {1'b1, 4'h4};
         SEG_5:   res = {1'b1, 4'h5};
         SEG_6:   res = {1'b1, 4'h6};
         SEG_7:   res = {1'b1, 4'h7};
         SEG_8:   res = {1'b1, 4'h8};
         SEG_9:   res = {1'b1, 4'h9};
         SEG_A:   res = {1'b1, 4'hA};
         SEG_B:   res = {1'b1, 4'hB};
         SEG_C:   res = {1'b1, 4'hC};
         SEG_D:   res = {1'b1, 4'hD};
         SEG_E:   res = {1'b1, 4'hE};
         SEG_F:   res = {1'b1, 4'hF};
         default: res = 5'b0_0000;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/seg7_rx_if.sv
// Segment bus input plus decoded status/counters of the receiver.
interface seg7_rx_if #(parameter int CNT_W = 8);
   logic [6:0]       seg_in;
   logic             clear;
   logic [3:0]       digit_out;
   logic             digit_valid;
   logic             blank;
   logic             code_err;
   logic             seq_err;
   logic [CNT_W-1:0] match_count;
   logic [CNT_W-1:0] err_count;

   modport master (
      output seg_in, clear,
      input  digit_out, digit_valid, blank, code_err, seq_err, match_count, err_count
   );

   modport slave (
      input  seg_in, clear,
      output digit_out, digit_valid, blank, code_err, seq_err, match_count, err_count
   );
endinterface

// File: rtl/seg7_stable_filter.sv
// Synchronizes the segment bus and emits one accept pulse per distinct stable pattern.
module seg7_stable_filter #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] i_seg,
   output logic       o_accept,
   output logic [6:0] o_pattern
);

   localparam logic [7:0] L_STABLE = 8'(STABLE_CYCLES);
   localparam logic [7:0] L_PRE    = 8'(STABLE_CYCLES - 1);

   logic [6:0] r_sync1;
   logic [6:0] r_sync2;
   logic [6:0] r_cand;
   logic [6:0] r_last;
   logic [7:0] r_stab;
   logic       w_accept;

   // Fires on the cycle whose edge brings the count to STABLE_CYCLES, so the
   // consumer registers its result on that same edge.
   assign w_accept  = (r_sync2 == r_cand) && (r_stab == L_PRE) && (r_cand != r_last);
   assign o_accept  = w_accept;
   assign o_pattern = r_cand;

   // Synchronizer, candidate tracking and saturating stability count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_cand  <= '0;
         r_last  <= '0;
         r_stab  <= '0;
      end else begin
         r_sync1 <= i_seg;
         r_sync2 <= r_sync1;
         if (r_sync2 != r_cand) begin
            r_cand <= r_sync2;
            r_stab <= 8'd1;
         end else if (r_stab != L_STABLE) begin
            r_stab <= r_stab + 8'd1;
         end
         if (w_accept) r_last <= r_cand;
      end
   end

endmodule

// File: rtl/seg7_rx.sv
// 7-segment receiver: decodes stable patterns and checks a +1 counting sequence.
//
//   state   | meaning
//   S_FIRST | no reference digit; next valid digit is taken as-is
//   S_RUN   | digit_out is the reference for the next in-sequence check
module seg7_rx
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input logic       clk,
   input logic       rst,
   seg7_rx_if.slave  bus
);

   logic             w_accept;
   logic [6:0]       w_pattern;
   logic [4:0]       w_dec;
   logic [3:0]       w_digit_inc;
   rx_state_t        r_state, w_state_nxt;
   logic             w_dv, w_ce, w_se, w_load, w_blank_nxt, w_match_inc, w_err_inc;
   logic [3:0]       r_digit;
   logic             r_dv, r_ce, r_se, r_blank;
   logic [CNT_W-1:0] r_match, r_err;

   seg7_stable_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
      .clk       (clk),
      .rst       (rst),
      .i_seg     (bus.seg_in),
      .o_accept  (w_accept),
      .o_pattern (w_pattern)
   );

   assign w_dec       = seg7_decode(w_pattern);
   assign w_digit_inc = r_digit + 4'd1;

   // Next state and per-accept actions.
   always_comb begin
      w_state_nxt = r_state;
      w_dv        = 1'b0;
      w_ce        = 1'b0;
      w_se        = 1'b0;
      w_load      = 1'b0;
      w_blank_nxt = r_blank;
      w_match_inc = 1'b0;
      w_err_inc   = 1'b0;
      if (w_accept) begin
         if (w_pattern == SEG_BLANK) begin
            w_blank_nxt = 1'b1;
            w_state_nxt = S_FIRST;
         end else if (!w_dec[4]) begin
            w_ce        = 1'b1;
            w_err_inc   = 1'b1;
            w_blank_nxt = 1'b0;
            w_state_nxt = S_FIRST;
         end else begin
            w_dv        = 1'b1;
            w_load      = 1'b1;
            w_blank_nxt = 1'b0;
            w_state_nxt = S_RUN;
            if (r_state == S_RUN) begin
               if (w_dec[3:0] == w_digit_inc) w_match_inc = 1'b1;
               else begin
                  w_se      = 1'b1;
                  w_err_inc = 1'b1;
               end
            end
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FIRST;
      else     r_state <= w_state_nxt;
   end

   // Registered digit, blank level and one-cycle strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_digit <= '0;
         r_blank <= 1'b0;
         r_dv    <= 1'b0;
         r_ce    <= 1'b0;
         r_se    <= 1'b0;
      end else begin
         if (w_load) r_digit <= w_dec[3:0];
         r_blank <= w_blank_nxt;
         r_dv    <= w_dv;
         r_ce    <= w_ce;
         r_se    <= w_se;
      end
   end

   // Counters: match wraps, errors saturate, clear wins over increments.
   always_ff @(posedge clk) begin
      if (rst || bus.clear) begin
         r_match <= '0;
         r_err   <= '0;
      end else begin
         if (w_match_inc) r_match <= r_match + 1'b1;
         if (w_err_inc && (r_err != '1)) r_err <= r_err + 1'b1;
      end
   end

   assign bus.digit_out   = r_digit;
   assign bus.digit_valid = r_dv;
   assign bus.blank       = r_blank;
   assign bus.code_err    = r_ce;
   assign bus.seq_err     = r_se;
   assign bus.match_count = r_match;
   assign bus.err_count   = r_err;

endmodule

// File: tb/tb_seg7_rx.sv
// Bench for seg7_rx: directed scenarios plus randomized pattern streams
// checked cycle by cycle against a behavioural digit-sequence model.
module tb_seg7_rx;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seg7_rx_if #(.CNT_W(8)) bus ();

   seg7_rx #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_pass  = 0;
   int n_total = 0;

   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Model of what the receiver has concluded so far.
   logic [6:0] m_last;
   int         m_digit, m_match, m_err;
   bit         m_have, m_blank;
   bit         e_dv, e_ce, e_se;

   function automatic int find_digit(input logic [6:0] p);
      for (int i = 0; i < 16; i++) if (glyph[i] == p) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_last = 7'h00; m_digit = 0; m_match = 0; m_err = 0;
      m_have = 0; m_blank = 0; e_dv = 0; e_ce = 0; e_se = 0;
   endtask

   task automatic model_accept(input logic [6:0] p);
      int d;
      d = find_digit(p);
      m_last = p;
      if (p == 7'h00) begin
         m_blank = 1; m_have = 0;
      end else if (d < 0) begin
         e_ce = 1; m_blank = 0; m_have = 0;
         if (m_err < 255) m_err++;
      end else begin
         e_dv = 1; m_blank = 0;
         if (m_have) begin
            if (d == (m_digit + 1) % 16) m_match = (m_match + 1) % 256;
            else begin
               e_se = 1;
               if (m_err < 255) m_err++;
            end
         end
         m_digit = d; m_have = 1;
      end
   endtask

   // Drive pat (new at the next edge N) for hold edges; clear is high across edge
   // N+clr_at. A pattern held >= 6 edges and differing from the last accepted one
   // must produce its result exactly at edge N+5. Every edge is compared.
   task automatic hold_pattern(input logic [6:0] pat, input int hold, input int clr_at, input string tag);
      logic [23:0] obs, expv;
      @(negedge clk);
      bus.seg_in = pat;
      for (int k = 0; k < hold; k++) begin
         bus.clear = (k == clr_at);
         @(posedge clk);
         #1;
         e_dv = 0; e_ce = 0; e_se = 0;
         if (k == 5 && hold > 5 && pat != m_last) model_accept(pat);
         if (k == clr_at) begin m_match = 0; m_err = 0; end
         obs  = {bus.digit_valid, bus.code_err, bus.seq_err, bus.blank,
                 bus.digit_out, bus.match_count, bus.err_count};
         expv = {e_dv, e_ce, e_se, m_blank, 4'(m_digit), 8'(m_match), 8'(m_err)};
         n_total++;
         if (obs !== expv)
            $display("FAIL %s pat=%h edge+%0d: got dv/ce/se/blank=%b digit=%h match=%0d err=%0d, expected %b digit=%h match=%0d err=%0d",
                     tag, pat, k, obs[23:20], obs[19:16], obs[15:8], obs[7:0],
                     expv[23:20], expv[19:16], expv[15:8], expv[7:0]);
         else n_pass++;
      end
      bus.clear = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.seg_in = 7'h00; bus.clear = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      hold_pattern(7'h00, 20, -1, "reset_idle");
   endtask

   task automatic test_count();
      hold_pattern(7'h3F, 8, -1, "count0");
      hold_pattern(7'h06, 8, -1, "count1");
      hold_pattern(7'h5B, 8, -1, "count2");
      n_total++;
      if (bus.digit_out !== 4'h2 || bus.match_count !== 8'd2 || bus.err_count !== 8'd0)
         $display("FAIL count_end: got digit=%h match=%0d err=%0d, expected 2 2 0",
                  bus.digit_out, bus.match_count, bus.err_count);
      else n_pass++;
   endtask

   task automatic test_glitch();
      int err_before;
      hold_pattern(7'h06, 8, -1, "glitch_base");
      hold_pattern(7'h4F, 2, -1, "glitch_short");
      hold_pattern(7'h06, 8, -1, "glitch_return");
      err_before = m_err;
      hold_pattern(7'h66, 8, -1, "glitch_seqerr");
      hold_pattern(7'h6D, 8, -1, "glitch_resync");
      n_total++;
      if (bus.digit_out !== 4'h5 || bus.err_count !== 8'(err_before + 1))
         $display("FAIL glitch_end: got digit=%h err=%0d, expected 5 %0d",
                  bus.digit_out, bus.err_count, err_before + 1);
      else n_pass++;
   endtask

   task automatic test_wrap();
      int match_before;
      hold_pattern(7'h71, 8, -1, "wrap_F");
      match_before = m_match;
      hold_pattern(7'h3F, 8, -1, "wrap_0");
      n_total++;
      if (bus.match_count !== 8'(match_before + 1) || bus.digit_out !== 4'h0)
         $display("FAIL wrap_step: got match=%0d digit=%h, expected %0d 0",
                  bus.match_count, bus.digit_out, match_before + 1);
      else n_pass++;
      hold_pattern(7'h12, 8, -1, "wrap_illegal");
      hold_pattern(7'h06, 8, -1, "wrap_after_illegal");
   endtask

   task automatic test_blank();
      hold_pattern(7'h00, 8, -1, "blank_on");
      n_total++;
      if (bus.blank !== 1'b1)
         $display("FAIL blank_level: got %b, expected 1", bus.blank);
      else n_pass++;
      hold_pattern(7'h7F, 8, -1, "blank_off");
      n_total++;
      if (bus.blank !== 1'b0 || bus.digit_out !== 4'h8)
         $display("FAIL blank_exit: got blank=%b digit=%h, expected 0 8", bus.blank, bus.digit_out);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [6:0] p, prev;
      int sel, hold, clr;
      for (int n = 0; n < 80; n++) begin
         sel  = $urandom_range(0, 9);
         hold = $urandom_range(6, 10);
         clr  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, hold - 1) : -1;
         if (sel <= 5)      p = glyph[(m_digit + 1) % 16];
         else if (sel == 6) p = glyph[$urandom_range(0, 15)];
         else if (sel == 7) p = 7'h00;
         else begin
            do p = 7'($urandom_range(1, 127)); while (find_digit(p) >= 0);
         end
         if (sel == 9) begin
            prev = m_last;
            hold_pattern(p, $urandom_range(1, 2), -1, "rand_glitch");
            hold_pattern(prev, hold, clr, "rand_glitch_ret");
         end else begin
            hold_pattern(p, hold, clr, "rand");
         end
      end
   endtask

   task automatic test_saturate();
      bit alt = 0;
      while (m_err < 255) begin
         hold_pattern(alt ? 7'h12 : 7'h13, 6, -1, "sat_fill");
         alt = ~alt;
      end
      hold_pattern(alt ? 7'h12 : 7'h13, 6, -1, "sat_hold");
      n_total++;
      if (bus.err_count !== 8'hFF)
         $display("FAIL sat_level: got err=%0d, expected 255", bus.err_count);
      else n_pass++;
      hold_pattern(7'h3F, 6, -1, "clr_first");
      hold_pattern(7'h06, 8, 5, "clr_vs_match");
      n_total++;
      if (bus.match_count !== 8'd0 || bus.err_count !== 8'd0)
         $display("FAIL clr_wins: got match=%0d err=%0d, expected 0 0", bus.match_count, bus.err_count);
      else n_pass++;
   endtask

   task automatic test_rst_pending();
      hold_pattern(7'h7D, 3, -1, "rst_pending");
      @(negedge clk);
      rst = 1'b1; bus.seg_in = 7'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      hold_pattern(7'h00, 20, -1, "rst_discard");
   endtask

   initial begin
      rst = 1'b1; bus.seg_in = 7'h00; bus.clear = 1'b0;
      model_reset();
      test_reset();
      test_count();
      test_glitch();
      test_wrap();
      test_blank();
      test_random();
      test_saturate();
      test_rst_pending();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
